// File: rtl/instr_fetch_queue.sv
// Instruction fetch stage: single-outstanding memory fetch into a small FIFO,
// presenting the head instruction, its decoded immediate and its PC to the decoder.
module instr_fetch_queue #(
    parameter int          QDEPTH   = 4,
    parameter logic [31:0] RESET_PC = 32'h0
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_rdy,
    output logic        o_mem_req,
    output logic [31:0] o_mem_addr,
    input  logic        i_mem_valid,
    input  logic [31:0] i_mem_data,
    input  logic        i_jump_flag,
    input  logic [31:0] i_jump_pc,
    input  logic        i_dec_stall,
    output logic [31:0] o_ins,
    output logic [31:0] o_ins_imm,
    output logic [31:0] o_ins_pc,
    output logic        o_ins_flag
);

    localparam int          PW      = $clog2(QDEPTH);
    localparam logic [PW:0] DEPTH_L = (PW + 1)'(QDEPTH);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WAIT    = 2'd1,
        ST_DISCARD = 2'd2
    } state_t;

    logic [31:0]   r_ins_mem [QDEPTH];
    logic [31:0]   r_pc_mem  [QDEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [PW:0]   r_count;
    logic [31:0]   r_pc;
    logic          r_mem_req;
    logic [31:0]   r_mem_addr;
    state_t        r_state;

    logic          w_not_empty;
    logic          w_deq;
    logic          w_enq;
    logic [31:0]   w_head_ins;
    logic [31:0]   w_head_pc;
    logic [31:0]   w_imm;

    assign w_not_empty = (r_count != '0);
    assign w_deq       = i_rdy & ~i_dec_stall & ~i_jump_flag & w_not_empty;
    assign w_enq       = i_rdy & ~i_jump_flag & (r_state == ST_WAIT) & i_mem_valid;

    // Entry storage needs no reset: occupancy is tracked by r_count alone.
    always_ff @(posedge i_clk) begin
        if (w_enq) begin
            r_ins_mem[r_wr_ptr] <= i_mem_data;
            r_pc_mem[r_wr_ptr]  <= r_mem_addr;
        end
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else if (i_rdy) begin
            if (i_jump_flag) begin
                r_rd_ptr <= '0;
                r_wr_ptr <= '0;
                r_count  <= '0;
            end else begin
                if (w_deq) r_rd_ptr <= r_rd_ptr + 1'b1;
                if (w_enq) r_wr_ptr <= r_wr_ptr + 1'b1;
                case ({w_enq, w_deq})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end
        end
    end

    // A redirect during WAIT leaves one response owed by memory; DISCARD absorbs it.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state    <= ST_IDLE;
            r_mem_req  <= 1'b0;
            r_mem_addr <= 32'h0;
            r_pc       <= RESET_PC;
        end else if (i_rdy) begin
            if (i_jump_flag) begin
                r_pc <= i_jump_pc;
                if (r_state == ST_WAIT) begin
                    r_mem_req <= 1'b0;
                    r_state   <= i_mem_valid ? ST_IDLE : ST_DISCARD;
                end else if (r_state == ST_DISCARD && i_mem_valid) begin
                    r_state <= ST_IDLE;
                end
            end else begin
                case (r_state)
                    ST_IDLE: begin
                        if (r_count < DEPTH_L) begin
                            r_mem_req  <= 1'b1;
                            r_mem_addr <= r_pc;
                            r_state    <= ST_WAIT;
                        end
                    end
                    ST_WAIT: begin
                        if (i_mem_valid) begin
                            r_pc      <= r_pc + 32'd4;
                            r_mem_req <= 1'b0;
                            r_state   <= ST_IDLE;
                        end
                    end
                    ST_DISCARD: begin
                        if (i_mem_valid) r_state <= ST_IDLE;
                    end
                    default: begin
                        r_mem_req <= 1'b0;
                        r_state   <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign w_head_ins = w_not_empty ? r_ins_mem[r_rd_ptr] : 32'h0;
    assign w_head_pc  = w_not_empty ? r_pc_mem[r_rd_ptr]  : 32'h0;

    always_comb begin
        w_imm = 32'h0;
        case (w_head_ins[6:0])
            7'b0000011, 7'b1100111: w_imm = {{20{w_head_ins[31]}}, w_head_ins[31:20]};
            7'b0010011: begin
                if (w_head_ins[14:12] == 3'b001 || w_head_ins[14:12] == 3'b101)
                    w_imm = {27'b0, w_head_ins[24:20]};
                else
                    w_imm = {{20{w_head_ins[31]}}, w_head_ins[31:20]};
            end
            7'b0100011: w_imm = {{20{w_head_ins[31]}}, w_head_ins[31:25], w_head_ins[11:7]};
            7'b1100011: w_imm = {{20{w_head_ins[31]}}, w_head_ins[7], w_head_ins[30:25],
                                 w_head_ins[11:8], 1'b0};
            7'b0110111, 7'b0010111: w_imm = {w_head_ins[31:12], 12'b0};
            7'b1101111: w_imm = {{12{w_head_ins[31]}}, w_head_ins[19:12], w_head_ins[20],
                                 w_head_ins[30:21], 1'b0};
            default: w_imm = 32'h0;
        endcase
    end

    assign o_mem_req  = r_mem_req;
    assign o_mem_addr = r_mem_addr;
    assign o_ins      = w_head_ins;
    assign o_ins_pc   = w_head_pc;
    assign o_ins_imm  = w_imm;
    assign o_ins_flag = w_deq;

endmodule

// File: tb/tb_instr_fetch_queue.sv
// Bench for instr_fetch_queue: table of instruction words, directed corner sequences and
// a randomized run, all checked against a queue-based reference model and a memory responder.
module tb_instr_fetch_queue;

    localparam int QDEPTH = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        rdy = 1'b0;
    logic        mem_valid = 1'b0;
    logic [31:0] mem_data = 32'h0;
    logic        jump = 1'b0;
    logic [31:0] jpc = 32'h0;
    logic        stall = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic [31:0] ins;
    logic [31:0] ins_imm;
    logic [31:0] ins_pc;
    logic        ins_flag;

    always #5 clk = ~clk;

    instr_fetch_queue #(.QDEPTH(QDEPTH), .RESET_PC(32'h0)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_rdy      (rdy),
        .o_mem_req  (mem_req),
        .o_mem_addr (mem_addr),
        .i_mem_valid(mem_valid),
        .i_mem_data (mem_data),
        .i_jump_flag(jump),
        .i_jump_pc  (jpc),
        .i_dec_stall(stall),
        .o_ins      (ins),
        .o_ins_imm  (ins_imm),
        .o_ins_pc   (ins_pc),
        .o_ins_flag (ins_flag)
    );

    typedef struct {
        logic [31:0] data;
        logic [31:0] pc;
    } ent_t;

    typedef struct {
        logic [31:0] word;
        logic [31:0] imm;
    } vec_t;

    ent_t        m_q[$];
    logic [31:0] m_pc = 32'h0;
    bit          busy = 1'b0;
    bit          stale = 1'b0;
    int          lat = 0;
    int          lat_cfg = 0;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] next_data = 32'h0;
    bit          delivered = 1'b0;
    int          checks = 0;
    int          errors = 0;
    vec_t        vecs[13];

    function automatic logic [31:0] ref_imm(logic [31:0] w);
        logic [6:0]  op = w[6:0];
        logic [2:0]  f3 = w[14:12];
        logic [11:0] s  = {w[31:25], w[11:7]};
        logic [12:0] b  = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        logic [20:0] j  = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        if (op == 7'h13 && (f3 == 3'd1 || f3 == 3'd5)) return {27'b0, w[24:20]};
        case (op)
            7'h03, 7'h67, 7'h13: return 32'($signed(w[31:20]));
            7'h23:               return 32'($signed(s));
            7'h63:               return 32'($signed(b));
            7'h37, 7'h17:        return w & 32'hFFFF_F000;
            7'h6F:               return 32'($signed(j));
            default:             return 32'h0;
        endcase
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock: drive at negedge, compare against the model, then advance the model at posedge.
    task automatic step();
        bit          exp_flag;
        bit          req_s;
        logic [31:0] addr_s;
        logic [31:0] eins;
        logic [31:0] epc;
        @(negedge clk);
        mem_valid = busy && (lat == 0) && rdy && rst;
        mem_data  = next_data;
        #1;
        exp_flag = rdy && !stall && !jump && (m_q.size() != 0);
        eins = 32'h0;
        epc  = 32'h0;
        if (m_q.size() != 0) begin
            eins = m_q[0].data;
            epc  = m_q[0].pc;
        end
        chk("ins_flag", {31'b0, ins_flag}, {31'b0, exp_flag});
        chk("ins", ins, eins);
        chk("ins_pc", ins_pc, epc);
        chk("ins_imm", ins_imm, ref_imm(eins));
        req_s  = mem_req;
        addr_s = mem_addr;
        if (busy && rst) begin
            chk("mem_req_hold", {31'b0, req_s}, {31'b0, !stale});
            if (!stale) chk("mem_addr_hold", addr_s, req_addr);
        end
        @(posedge clk);
        delivered = 1'b0;
        if (!rst) begin
            m_q.delete();
            m_pc  = 32'h0;
            busy  = 1'b0;
            stale = 1'b0;
        end else if (rdy) begin
            if (exp_flag) void'(m_q.pop_front());
            if (mem_valid) begin
                if (!stale && !jump) begin
                    m_q.push_back('{data: mem_data, pc: req_addr});
                    m_pc = m_pc + 32'd4;
                    delivered = 1'b1;
                end
                busy  = 1'b0;
                stale = 1'b0;
            end else if (busy) begin
                if (lat > 0) lat--;
            end else if (req_s) begin
                chk("mem_addr_issue", addr_s, m_pc);
                busy     = 1'b1;
                lat      = lat_cfg;
                req_addr = addr_s;
                stale    = jump;
            end
            if (jump) begin
                m_q.delete();
                m_pc = jpc;
                if (busy) stale = 1'b1;
            end
            chk("fifo_bound", {31'b0, m_q.size() <= QDEPTH}, 32'd1);
        end
        #1;
    endtask

    task automatic fetch_word(logic [31:0] w);
        int n = 0;
        next_data = w;
        lat_cfg   = 0;
        delivered = 1'b0;
        while (!delivered && n < 30) begin
            step();
            n++;
        end
        chk("fetch_timeout", {31'b0, delivered}, 32'd1);
    endtask

    task automatic redirect(logic [31:0] target);
        jump = 1'b1;
        jpc  = target;
        step();
        jump = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int          n;
        int          r;
        logic [31:0] s_addr;
        logic [31:0] s_pc;
        bit          s_req;

        vecs[0]  = '{32'h00500093, 32'h00000005};
        vecs[1]  = '{32'hFE000EE3, 32'hFFFFFFFC};
        vecs[2]  = '{32'h4030D093, 32'h00000003};
        vecs[3]  = '{32'h123450B7, 32'h12345000};
        vecs[4]  = '{32'hFFF00113, 32'hFFFFFFFF};
        vecs[5]  = '{32'hFE112E23, 32'hFFFFFFFC};
        vecs[6]  = '{32'h0080006F, 32'h00000008};
        vecs[7]  = '{32'hABCDE017, 32'hABCDE000};
        vecs[8]  = '{32'h002081B3, 32'h00000000};
        vecs[9]  = '{32'h80012083, 32'hFFFFF800};
        vecs[10] = '{32'hFFC08067, 32'hFFFFFFFC};
        vecs[11] = '{32'h01F09093, 32'h0000001F};
        vecs[12] = '{32'h00208463, 32'h00000008};

        // Reset held for two cycles
        rst = 1'b0;
        rdy = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        m_q.delete();
        m_pc = 32'h0;
        chk("rst_mem_req", {31'b0, mem_req}, 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_ins_flag", {31'b0, ins_flag}, 32'd0);
        chk("rst_ins", ins, 32'd0);
        chk("rst_ins_imm", ins_imm, 32'd0);
        chk("rst_ins_pc", ins_pc, 32'd0);
        rst = 1'b1;
        step();
        chk("first_req", {31'b0, mem_req}, 32'd1);
        chk("first_addr", mem_addr, 32'd0);

        // Instruction words and their immediates
        for (int i = 0; i < 13; i++) begin
            fetch_word(vecs[i].word);
            chk("vec_flag", {31'b0, ins_flag}, 32'd1);
            chk("vec_ins", ins, vecs[i].word);
            chk("vec_imm", ins_imm, vecs[i].imm);
            if (i == 0) begin
                chk("vec0_pc", ins_pc, 32'd0);
                step();
                chk("next_req", {31'b0, mem_req}, 32'd1);
                chk("next_addr", mem_addr, 32'd4);
            end
        end

        // Decoder stall fills the FIFO; release drains in order
        redirect(32'h0);
        stall     = 1'b1;
        lat_cfg   = 0;
        next_data = 32'h00100013;
        n = 0;
        while (m_q.size() < QDEPTH && n < 60) begin
            step();
            n++;
        end
        chk("fill_count", m_q.size(), QDEPTH);
        repeat (3) begin
            step();
            chk("full_no_req", {31'b0, mem_req}, 32'd0);
        end
        lat_cfg = 3;
        stall   = 1'b0;
        for (int i = 0; i < QDEPTH; i++) begin
            #1;
            chk("drain_flag", {31'b0, ins_flag}, 32'd1);
            chk("drain_pc", ins_pc, 32'(i * 4));
            step();
        end
        chk("resume_req", {31'b0, mem_req}, 32'd1);
        chk("resume_addr", mem_addr, 32'h10);

        // Redirect while the fetch of 0x8 is in flight
        redirect(32'h0);
        lat_cfg = 3;
        n = 0;
        while (!(busy && !stale && req_addr == 32'h8) && n < 80) begin
            step();
            n++;
        end
        chk("inflight_8", {31'b0, busy && req_addr == 32'h8}, 32'd1);
        jump = 1'b1;
        jpc  = 32'h100;
        #1;
        chk("jump_no_flag", {31'b0, ins_flag}, 32'd0);
        step();
        jump = 1'b0;
        #1;
        chk("flush_flag", {31'b0, ins_flag}, 32'd0);
        chk("flush_ins", ins, 32'd0);
        n = 0;
        while (!mem_req && n < 20) begin
            step();
            n++;
        end
        chk("redirect_req", {31'b0, mem_req}, 32'd1);
        chk("redirect_addr", mem_addr, 32'h100);

        // Freeze with rdy low while waiting on memory, with entries queued
        stall = 1'b1;
        n = 0;
        while (!(busy && !stale && m_q.size() > 0) && n < 40) begin
            step();
            n++;
        end
        chk("freeze_setup", {31'b0, busy && m_q.size() > 0}, 32'd1);
        stall  = 1'b0;
        s_req  = mem_req;
        s_addr = mem_addr;
        s_pc   = ins_pc;
        rdy    = 1'b0;
        repeat (3) begin
            step();
            chk("freeze_req", {31'b0, mem_req}, {31'b0, s_req});
            chk("freeze_addr", mem_addr, s_addr);
            chk("freeze_flag", {31'b0, ins_flag}, 32'd0);
            chk("freeze_pc", ins_pc, s_pc);
        end
        rdy = 1'b1;
        step();

        // Randomized traffic, including redirects near the top of the address space
        for (int c = 0; c < 3000; c++) begin
            rdy   = ($urandom_range(0, 9) != 0);
            stall = ($urandom_range(0, 3) == 0);
            jump  = ($urandom_range(0, 24) == 0);
            r = $urandom_range(0, 3);
            if (r == 0) jpc = 32'hFFFF_FFF0 + 32'($urandom_range(0, 3) * 4);
            else        jpc = $urandom() & 32'hFFFF_FFFC;
            lat_cfg = $urandom_range(0, 3);
            if ($urandom_range(0, 2) == 0) next_data = $urandom();
            else next_data = vecs[$urandom_range(0, 12)].word;
            step();
        end
        jump = 1'b0;
        rdy  = 1'b1;
        repeat (10) step();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
